// File: rtl/regfile_wport_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wport_arbiter
//
// Owns the single write port of the 32x32 register file (x0 reads as zero).
// The in-order pipeline writeback (WB) and NUM_EXT long-latency units share
// that port. WB normally has priority. The ext units arbitrate round-robin
// among themselves. A starvation counter makes WB yield for one cycle after
// STARVE_LIMIT consecutive wins while an ext unit is waiting.
// A per-register busy scoreboard is kept for the hazard logic. An alloc sets
// the busy bit, and the commit of an ext-sourced write clears it.
//
// Ports
//   clk, reset_n               clock (rising edge), async active-low reset
//   wb_valid/addr/data         pipeline writeback request (no ready)
//   pipe_stall                 WB must hold wb_* this cycle (forced yield)
//   ext_valid/ready/addr/data  ext unit write requests, valid/ready handshake
//   alloc_valid/alloc_addr     reserve a destination for an issued ext op
//   busy                       scoreboard, busy[0] always 0
//   rf_wrd/rf_addr_d/rf_d      registered regfile write port
// -----------------------------------------------------------------------------
module regfile_wport_arbiter #(
    parameter int NUM_EXT      = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wb_valid,
    input  logic [4:0]                    wb_addr,
    input  logic [DATA_WIDTH-1:0]         wb_data,
    output logic                          pipe_stall,
    input  logic [NUM_EXT-1:0]            ext_valid,
    output logic [NUM_EXT-1:0]            ext_ready,
    input  logic [NUM_EXT*5-1:0]          ext_addr,
    input  logic [NUM_EXT*DATA_WIDTH-1:0] ext_data,
    input  logic                          alloc_valid,
    input  logic [4:0]                    alloc_addr,
    output logic [31:0]                   busy,
    output logic                          rf_wrd,
    output logic [4:0]                    rf_addr_d,
    output logic [DATA_WIDTH-1:0]         rf_d
);

    localparam int PTR_W = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      rr_nxt;
    logic [CNT_W-1:0]      starve_cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  stall_nxt;
    logic                  rf_ext;
    logic [31:0]           busy_q;
    logic [31:0]           busy_nxt;

    logic                  wb_grant;
    logic                  ext_acc;
    logic                  grant;
    logic                  any_ext;
    logic                  found;
    logic [NUM_EXT-1:0]    hi_req;
    logic [NUM_EXT-1:0]    pick_src;
    logic [NUM_EXT-1:0]    ext_gnt;
    logic [4:0]            ext_sel_addr;
    logic [DATA_WIDTH-1:0] ext_sel_data;
    logic [4:0]            win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    // During the forced-yield cycle WB is ignored even if it is valid.
    assign wb_grant = wb_valid & ~pipe_stall;
    assign any_ext  = |ext_valid;

    // Round-robin pick. Requests at or above the pointer are searched first.
    // If there are none, the lowest index overall wins (wrap-around).
    always_comb begin
        hi_req = '0;
        for (int i = 0; i < NUM_EXT; i++) begin
            if (i >= int'(rr_ptr)) begin
                hi_req[i] = ext_valid[i];
            end
        end
        pick_src = (|hi_req) ? hi_req : ext_valid;
        ext_gnt  = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_EXT; i++) begin
            if (!found && pick_src[i]) begin
                ext_gnt[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        ext_sel_addr = '0;
        ext_sel_data = '0;
        rr_nxt       = rr_ptr;
        for (int i = 0; i < NUM_EXT; i++) begin
            if (ext_gnt[i]) begin
                ext_sel_addr = ext_addr[5*i +: 5];
                ext_sel_data = ext_data[DATA_WIDTH*i +: DATA_WIDTH];
                rr_nxt       = PTR_W'((i + 1) % NUM_EXT);
            end
        end
    end

    // ext_ready is built only from valids and state, never from addr or data.
    assign ext_ready = (reset_n && !wb_grant) ? ext_gnt : '0;
    assign ext_acc   = |ext_ready;
    assign grant     = wb_grant | ext_acc;
    assign win_addr  = wb_grant ? wb_addr : ext_sel_addr;
    assign win_data  = wb_grant ? wb_data : ext_sel_data;

    // Starvation counter. WB may win only STARVE_LIMIT times in a row while an
    // ext request waits. The next cycle is then a one-cycle forced yield.
    always_comb begin
        cnt_nxt   = starve_cnt;
        stall_nxt = 1'b0;
        if (wb_grant && any_ext) begin
            if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
                stall_nxt = 1'b1;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = starve_cnt + 1'b1;
            end
        end else if (ext_acc || !any_ext) begin
            cnt_nxt = '0;
        end
    end

    // Scoreboard. An ext write clears the bit at the edge that commits it into
    // the regfile. An alloc at the same edge wins over the clear.
    always_comb begin
        busy_nxt = busy_q;
        if (rf_wrd && rf_ext) begin
            busy_nxt[rf_addr_d] = 1'b0;
        end
        if (alloc_valid && (alloc_addr != 5'd0)) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    assign busy = busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_wrd     <= 1'b0;
            rf_addr_d  <= '0;
            rf_d       <= '0;
            rf_ext     <= 1'b0;
            rr_ptr     <= '0;
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
            busy_q     <= '0;
        end else begin
            // A grant to x0 completes its handshake but never writes.
            rf_wrd     <= grant && (win_addr != 5'd0);
            rf_ext     <= ext_acc;
            if (grant) begin
                rf_addr_d <= win_addr;
                rf_d      <= win_data;
            end
            if (ext_acc) begin
                rr_ptr <= rr_nxt;
            end
            starve_cnt <= cnt_nxt;
            pipe_stall <= stall_nxt;
            busy_q     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
module tb_regfile_wport_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        pipe_stall;
    logic [1:0]  ext_valid = '0;
    logic [1:0]  ext_ready;
    logic [9:0]  ext_addr = '0;
    logic [63:0] ext_data = '0;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_addr = '0;
    logic [31:0] busy;
    logic        rf_wrd;
    logic [4:0]  rf_addr_d;
    logic [31:0] rf_d;

    int checks = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    regfile_wport_arbiter #(.NUM_EXT(2), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .pipe_stall(pipe_stall),
        .ext_valid(ext_valid), .ext_ready(ext_ready),
        .ext_addr(ext_addr), .ext_data(ext_data),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .busy(busy),
        .rf_wrd(rf_wrd), .rf_addr_d(rf_addr_d), .rf_d(rf_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every regfile write is popped and compared.
    always @(negedge clk) begin
        if (reset_n && rf_wrd) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rf_write", {27'd0, rf_addr_d, rf_d}, 64'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("rf_write", {27'd0, rf_addr_d, rf_d}, {27'd0, e});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held with random inputs
        for (int k = 0; k < 4; k++) begin
            wb_valid    = 1'($urandom);
            wb_addr     = 5'($urandom);
            wb_data     = $urandom;
            ext_valid   = 2'($urandom);
            ext_addr    = 10'($urandom);
            ext_data    = {$urandom, $urandom};
            alloc_valid = 1'b1;
            alloc_addr  = 5'($urandom_range(1, 31));
            step();
        end
        chk("reset_rf_wrd", 64'(rf_wrd), 64'd0);
        chk("reset_rf_addr_d", 64'(rf_addr_d), 64'd0);
        chk("reset_rf_d", 64'(rf_d), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_pipe_stall", 64'(pipe_stall), 64'd0);
        chk("reset_ext_ready", 64'(ext_ready), 64'd0);
        wb_valid = 0; ext_valid = 0; alloc_valid = 0;
        reset_n = 1'b1;
        step();
        chk("idle_rf_wrd", 64'(rf_wrd), 64'd0);

        // 2: single WB write
        wb_valid = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        #1 chk("wb_ext_ready", 64'(ext_ready), 64'd0);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        step();
        wb_valid = 0;
        step();

        // 3: both ext units, round-robin from pointer 0
        ext_valid = 2'b11;
        ext_addr  = {5'd4, 5'd3};
        ext_data  = {32'hA1A1A1A1, 32'hA0A0A0A0};
        #1 chk("rr_first_unit0", 64'(ext_ready), 64'd1);
        exp_q.push_back({5'd3, 32'hA0A0A0A0});
        step();
        ext_valid = 2'b10;
        #1 chk("rr_second_unit1", 64'(ext_ready), 64'd2);
        exp_q.push_back({5'd4, 32'hA1A1A1A1});
        step();
        ext_valid = 2'b00;
        step();

        // 4: starvation, 4 WB wins, then one forced yield to ext0
        ext_valid = 2'b01; ext_addr[4:0] = 5'd9; ext_data[31:0] = 32'hE0E0E0E0;
        wb_valid = 1;
        for (int k = 0; k < 4; k++) begin
            wb_addr = 5'(10 + k); wb_data = 32'h1000 + 32'(k);
            #1;
            chk("starve_no_stall", 64'(pipe_stall), 64'd0);
            chk("starve_wb_wins", 64'(ext_ready), 64'd0);
            exp_q.push_back({5'(10 + k), 32'h1000 + 32'(k)});
            step();
        end
        wb_addr = 5'd14; wb_data = 32'h1004;
        #1;
        chk("stall_pulse", 64'(pipe_stall), 64'd1);
        chk("stall_ext0_granted", 64'(ext_ready), 64'd1);
        exp_q.push_back({5'd9, 32'hE0E0E0E0});
        step();
        ext_valid = 2'b00;
        chk("stall_falls", 64'(pipe_stall), 64'd0);
        exp_q.push_back({5'd14, 32'h1004});
        step();
        wb_valid = 0;
        step();

        // 5: scoreboard
        alloc_valid = 1; alloc_addr = 5'd7;
        step();
        alloc_valid = 0;
        chk("busy7_set", 64'(busy[7]), 64'd1);
        wb_valid = 1; wb_addr = 5'd7; wb_data = 32'h77;
        exp_q.push_back({5'd7, 32'h77});
        step();
        wb_valid = 0;
        step();
        chk("busy7_wb_no_clear", 64'(busy[7]), 64'd1);
        ext_valid = 2'b01; ext_addr[4:0] = 5'd7; ext_data[31:0] = 32'h7E7E;
        exp_q.push_back({5'd7, 32'h7E7E});
        step();
        ext_valid = 2'b00;
        chk("busy7_during_write", 64'(busy[7]), 64'd1);
        step();
        chk("busy7_cleared", 64'(busy), 64'd0);
        alloc_valid = 1; alloc_addr = 5'd7;
        step();
        alloc_valid = 0;
        ext_valid = 2'b01; ext_data[31:0] = 32'h7F7F;
        exp_q.push_back({5'd7, 32'h7F7F});
        step();
        ext_valid = 2'b00;
        alloc_valid = 1; alloc_addr = 5'd7;
        step();
        alloc_valid = 0;
        chk("busy7_set_wins", 64'(busy), 64'h80);

        // 6: x0 write and alloc, then reset mid-grant
        ext_valid = 2'b10; ext_addr[9:5] = 5'd0; ext_data[63:32] = 32'h0BAD;
        #1 chk("x0_handshake", 64'(ext_ready), 64'd2);
        step();
        ext_valid = 2'b00;
        chk("x0_no_write", 64'(rf_wrd), 64'd0);
        alloc_valid = 1; alloc_addr = 5'd0;
        step();
        alloc_valid = 0;
        chk("x0_alloc_busy", 64'(busy), 64'h80);
        ext_valid = 2'b01; ext_addr[4:0] = 5'd5; ext_data[31:0] = 32'h5555;
        step();
        reset_n = 1'b0;
        #1;
        chk("midreset_rf_wrd", 64'(rf_wrd), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_ext_ready", 64'(ext_ready), 64'd0);
        ext_valid = 2'b00;
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
